timer_ctrl_master: RTL and testbench
====================================

TIMER_CTRL_MASTER -- requirements
Module: timer_ctrl_master

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, meaning width of tick_count (16..32).
REQ-002 The block SHALL have parameter RD_LAT, default 1, meaning fixed slave read latency in cycles (1..3).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1: sole clock, all logic on rising edge.
REQ-005 Port reset, input, 1: synchronous active-high reset.
REQ-006 Port cmd_start, input, 1: one-cycle pulse that programs and starts the timer.
REQ-007 Port cmd_stop, input, 1: one-cycle pulse that stops the timer.
REQ-008 Port cmd_period, input, 32: period value sampled on cmd_start.
REQ-009 Port cmd_continuous, input, 1: continuous-mode bit sampled on cmd_start.
REQ-010 Port snap_req, input, 1: snapshot request pulse (see Configuration).
REQ-011 Port avm_address, output, 3: slave register index.
REQ-012 Port avm_chipselect, output, 1: bus access valid.
REQ-013 Port avm_write_n, output, 1: low for write, high for read.
REQ-014 Port avm_writedata, output, 16: write data.
REQ-015 Port avm_readdata, input, 16: read data.
REQ-016 Port avm_waitrequest, input, 1: slave stall; tie 0 when unused.
REQ-017 Port irq_in, input, 1: timer interrupt (level).
REQ-018 Outputs: busy (1), tick (1-cycle pulse per serviced timeout), tick_count (CNT_W), running (1), snapshot (32), snap_valid (1).

Function
REQ-019 Slave map SHALL be 0 status {bit1 RUN, bit0 TO}, write clears TO; 1 control {bit3 STOP, bit2 START, bit1 CONT, bit0 ITO}; 2 period_l; 3 period_h; 4 snap_l; 5 snap_h.
REQ-020 A bus access SHALL hold address/chipselect/write_n/writedata stable until a cycle with avm_waitrequest=0; that cycle completes it.
REQ-021 Read data SHALL be captured exactly RD_LAT cycles after the completing read cycle; chipselect SHALL be 0 during those wait cycles.
REQ-022 FSM states SHALL be IDLE, WR_PL, WR_PH, WR_CTL, ARMED, CLR_TO, RD_STS, RD_WAIT, WR_STOP, SNAP_WR, SNAP_RDL, SNAP_RDH, SNAP_WAIT.
REQ-023 IDLE + cmd_start: latch period/continuous, go WR_PL (write period[15:0] to 2) -> WR_PH (period[31:16] to 3) -> WR_CTL (write {0,1,cont,1} to 1) -> ARMED; running=1 on WR_CTL completion.
REQ-024 ARMED + irq_in=1: CLR_TO (write 0 to 0), then RD_STS/RD_WAIT read status; tick pulses and tick_count increments (wrap to 0 at all-ones) when CLR_TO completes.
REQ-025 After RD_STS data: RUN=1 -> ARMED; RUN=0 -> running=0, IDLE.
REQ-026 cmd_stop in ARMED SHALL go WR_STOP (write 4'b1000 to 1), then IDLE, running=0; cmd_stop in other states SHALL be latched and serviced on next entry to ARMED.
REQ-027 cmd_start while busy SHALL be ignored; busy=1 in every state except IDLE and ARMED.
REQ-028 irq_in and cmd_stop same cycle in ARMED: service irq first, then stop.
REQ-029 chipselect SHALL be 0 in IDLE, ARMED, RD_WAIT, SNAP_WAIT.

Reset
REQ-030 On reset: state IDLE, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, busy=0, tick=0, tick_count=0, running=0, snapshot=0, snap_valid=0, pending stop cleared.
REQ-031 Reset mid-transfer SHALL drop chipselect the next cycle; no partial access resumes.

Configuration
REQ-032 Macro TIMER_CTRL_MASTER_SNAPSHOT_EN defined: snap_req in ARMED SHALL write 0 to 4, read 4 then 5, set snapshot={hi,lo} and pulse snap_valid one cycle, return ARMED; snap_req otherwise ignored.
REQ-033 Macro undefined: snapshot states absent, snap_req ignored, snapshot=0, snap_valid=0.

Verification
REQ-034 cmd_start, period=0x0001_86A0, cont=1, waitrequest=0 -> writes (2,0x86A0),(3,0x0001),(1,0x0007) on consecutive cycles; running=1.
REQ-035 ARMED, irq_in high, status read returns 0x0002 -> write (0,0x0000), tick pulse, tick_count 0->1, back ARMED.
REQ-036 Same with cont=0, status returns 0x0001 -> running=0, IDLE, busy=0.
REQ-037 waitrequest high 3 cycles on WR_PH -> address 3/data held 4 cycles, no write repeated.
REQ-038 cmd_stop during WR_PL -> sequence completes, then write (1,0x0008), IDLE.
REQ-039 SNAPSHOT_EN, snap_req in ARMED, reads 0x1234 then 0x0005 -> snapshot=0x0005_1234, snap_valid one cycle.

Source files
------------

// File: rtl/timer_ctrl_master.sv
// Bus master that programs and services a timer slave from cmd_* pulses; every access holds until waitrequest drops.
// Snapshot path (snap_req -> snapshot/snap_valid) is built only with TIMER_CTRL_MASTER_SNAPSHOT_EN defined.
module timer_ctrl_master #(
  parameter int CNT_W  = 32,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic [31:0]      cmd_period,
  input  logic             cmd_continuous,
  input  logic             snap_req,
  output logic [2:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [15:0]      avm_writedata,
  input  logic [15:0]      avm_readdata,
  input  logic             avm_waitrequest,
  input  logic             irq_in,
  output logic             busy,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             running,
  output logic [31:0]      snapshot,
  output logic             snap_valid
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] WR_PL   = 4'd1;
  localparam logic [3:0] WR_PH   = 4'd2;
  localparam logic [3:0] WR_CTL  = 4'd3;
  localparam logic [3:0] ARMED   = 4'd4;
  localparam logic [3:0] CLR_TO  = 4'd5;
  localparam logic [3:0] RD_STS  = 4'd6;
  localparam logic [3:0] RD_WAIT = 4'd7;
  localparam logic [3:0] WR_STOP = 4'd8;
`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
  localparam logic [3:0] SNAP_WR   = 4'd9;
  localparam logic [3:0] SNAP_RDL  = 4'd10;
  localparam logic [3:0] SNAP_RDH  = 4'd11;
  localparam logic [3:0] SNAP_WAIT = 4'd12;
`endif

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  logic [3:0]       state_q, state_d;
  logic [31:0]      period_q, period_d;
  logic             cont_q, cont_d;
  logic             stop_pend_q, stop_pend_d;
  logic             running_q, running_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]       lat_cnt_q, lat_cnt_d;
  logic             xfer_done;
  logic             lat_last;

  // Bus signals are a pure function of state, so a reset returns them to idle on the next cycle.
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 3'd0;
    avm_writedata  = 16'd0;
    case (state_q)
      WR_PL:   begin avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 3'd2; avm_writedata = period_q[15:0];  end
      WR_PH:   begin avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 3'd3; avm_writedata = period_q[31:16]; end
      WR_CTL:  begin avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 3'd1; avm_writedata = {13'd0, 1'b1, cont_q, 1'b1}; end
      CLR_TO:  begin avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 3'd0; end
      RD_STS:  begin avm_chipselect = 1'b1; avm_address = 3'd0; end
      WR_STOP: begin avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 3'd1; avm_writedata = 16'h0008; end
`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
      SNAP_WR:  begin avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 3'd4; end
      SNAP_RDL: begin avm_chipselect = 1'b1; avm_address = 3'd4; end
      SNAP_RDH: begin avm_chipselect = 1'b1; avm_address = 3'd5; end
`endif
      default: ;
    endcase
  end

  assign xfer_done = avm_chipselect && !avm_waitrequest;
  assign lat_last  = (lat_cnt_q == LAT_LAST);

`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
  logic        snap_hi_q, snap_hi_d;
  logic [15:0] snap_lo_q, snap_lo_d;
  logic [31:0] snapshot_q, snapshot_d;
  logic        snap_vld_q, snap_vld_d;
`endif

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    running_d   = running_q;
    tick_d      = 1'b0;
    tick_cnt_d  = tick_cnt_q;
    lat_cnt_d   = lat_cnt_q;
`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
    snap_hi_d   = snap_hi_q;
    snap_lo_d   = snap_lo_q;
    snapshot_d  = snapshot_q;
    snap_vld_d  = 1'b0;
`endif
    if (cmd_stop && state_q != IDLE) stop_pend_d = 1'b1;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (cmd_start) begin
          period_d = cmd_period;
          cont_d   = cmd_continuous;
          state_d  = WR_PL;
        end
      end
      WR_PL:  if (xfer_done) state_d = WR_PH;
      WR_PH:  if (xfer_done) state_d = WR_CTL;
      WR_CTL: if (xfer_done) begin
        running_d = 1'b1;
        state_d   = ARMED;
      end
      // A pending interrupt always wins over a stop or snapshot request.
      ARMED: begin
        if (irq_in) state_d = CLR_TO;
        else if (stop_pend_q || cmd_stop) begin
          stop_pend_d = 1'b0;
          state_d     = WR_STOP;
        end
`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
        else if (snap_req) state_d = SNAP_WR;
`endif
      end
      CLR_TO: if (xfer_done) begin
        tick_d     = 1'b1;
        tick_cnt_d = tick_cnt_q + CNT_W'(1);
        state_d    = RD_STS;
      end
      RD_STS: if (xfer_done) begin
        lat_cnt_d = 2'd0;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_last) begin
          if (avm_readdata[1]) state_d = ARMED;
          else begin
            running_d   = 1'b0;
            stop_pend_d = 1'b0;
            state_d     = IDLE;
          end
        end else lat_cnt_d = lat_cnt_q + 2'd1;
      end
      WR_STOP: if (xfer_done) begin
        running_d   = 1'b0;
        stop_pend_d = 1'b0;
        state_d     = IDLE;
      end
`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
      SNAP_WR:  if (xfer_done) state_d = SNAP_RDL;
      SNAP_RDL: if (xfer_done) begin
        snap_hi_d = 1'b0;
        lat_cnt_d = 2'd0;
        state_d   = SNAP_WAIT;
      end
      SNAP_RDH: if (xfer_done) begin
        snap_hi_d = 1'b1;
        lat_cnt_d = 2'd0;
        state_d   = SNAP_WAIT;
      end
      SNAP_WAIT: begin
        if (lat_last) begin
          if (!snap_hi_q) begin
            snap_lo_d = avm_readdata;
            state_d   = SNAP_RDH;
          end else begin
            snapshot_d = {avm_readdata, snap_lo_q};
            snap_vld_d = 1'b1;
            state_d    = ARMED;
          end
        end else lat_cnt_d = lat_cnt_q + 2'd1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      period_q    <= 32'd0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      running_q   <= 1'b0;
      tick_q      <= 1'b0;
      tick_cnt_q  <= '0;
      lat_cnt_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      running_q   <= running_d;
      tick_q      <= tick_d;
      tick_cnt_q  <= tick_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
    end
  end

`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_hi_q  <= 1'b0;
      snap_lo_q  <= 16'd0;
      snapshot_q <= 32'd0;
      snap_vld_q <= 1'b0;
    end else begin
      snap_hi_q  <= snap_hi_d;
      snap_lo_q  <= snap_lo_d;
      snapshot_q <= snapshot_d;
      snap_vld_q <= snap_vld_d;
    end
  end

  assign snapshot   = snapshot_q;
  assign snap_valid = snap_vld_q;
`else
  logic unused_snap;
  assign unused_snap = snap_req ^ (^{avm_readdata[15:2], avm_readdata[0]});
  assign snapshot    = 32'd0;
  assign snap_valid  = 1'b0;
`endif

  assign busy       = (state_q != IDLE) && (state_q != ARMED);
  assign tick       = tick_q;
  assign tick_count = tick_cnt_q;
  assign running    = running_q;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Randomized scoreboard bench for timer_ctrl_master: the stimulus side queues expected bus
// accesses, ticks and snapshots; a monitor pops and compares whenever the DUT presents one.
`timescale 1ns/1ps
module tb_timer_ctrl_master;
  localparam int CNT_W  = 32;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic reset;
  logic cmd_start, cmd_stop, cmd_continuous, snap_req, irq_in;
  logic [31:0] cmd_period;
  logic [2:0]  avm_address;
  logic        avm_chipselect, avm_write_n, avm_waitrequest;
  logic [15:0] avm_writedata, avm_readdata;
  logic        busy, tick, running, snap_valid;
  logic [CNT_W-1:0] tick_count;
  logic [31:0] snapshot;

  always #5 clk = ~clk;

  timer_ctrl_master #(.CNT_W(CNT_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_period(cmd_period),
    .cmd_continuous(cmd_continuous), .snap_req(snap_req),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .irq_in(irq_in), .busy(busy), .tick(tick), .tick_count(tick_count), .running(running),
    .snapshot(snapshot), .snap_valid(snap_valid)
  );

  int checks = 0;
  int errors = 0;

  // Expected completed accesses as {is_write, address, write data (0 for reads)}.
  logic [19:0]      exp_acc[$];
  logic [CNT_W-1:0] exp_tick[$];
  logic [31:0]      exp_snap[$];

  bit               m_running;
  logic [CNT_W-1:0] m_ticks;

  logic [15:0] sts_val, snap_lo, snap_hi;
  int          stall_pct;
  int          stall_ph;
  bit          force_wait;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] acc(input bit wr, input logic [2:0] a, input logic [15:0] d);
    return {wr, a, wr ? d : 16'h0000};
  endfunction

  // Slave: random stalls, read data valid only in the cycle exactly RD_LAT after completion.
  initial begin
    logic        dly_v[4];
    logic [15:0] dly_d[4];
    bit          st_ph;
    for (int i = 0; i < 4; i++) begin dly_v[i] = 1'b0; dly_d[i] = 16'h0; end
    avm_waitrequest = 1'b0;
    avm_readdata    = 16'hDEAD;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin dly_v[i] = dly_v[i+1]; dly_d[i] = dly_d[i+1]; end
      dly_v[3] = 1'b0;
      st_ph = avm_chipselect && !avm_write_n && avm_address == 3'd3 && stall_ph > 0;
      if (st_ph) stall_ph--;
      avm_waitrequest = force_wait || st_ph ||
                        (avm_chipselect && int'($urandom_range(99)) < stall_pct);
      if (avm_chipselect && avm_write_n && !avm_waitrequest && !reset) begin
        dly_v[RD_LAT] = 1'b1;
        dly_d[RD_LAT] = (avm_address == 3'd0) ? sts_val :
                        (avm_address == 3'd4) ? snap_lo :
                        (avm_address == 3'd5) ? snap_hi : 16'hBAD0;
      end
      avm_readdata = dly_v[0] ? dly_d[0] : 16'hDEAD;
    end
  end

  // Monitor
  initial begin
    bit          hold_v;
    logic [20:0] hold_k;
    int          rd_cnt;
    logic [19:0] e;
    hold_v = 1'b0;
    rd_cnt = 0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        hold_v = 1'b0;
        rd_cnt = 0;
      end else begin
        if (hold_v)
          check("bus_hold", 32'({avm_chipselect, avm_write_n, avm_address, avm_writedata}), 32'(hold_k));
        if (rd_cnt > 0) begin
          check("rd_wait_cs", 32'(avm_chipselect), 32'd0);
          rd_cnt--;
        end
        if (avm_chipselect && !avm_waitrequest) begin
          if (exp_acc.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected: got addr %0d wr %0b data 0x%04h expected no access",
                     avm_address, !avm_write_n, avm_writedata);
          end else begin
            e = exp_acc.pop_front();
            check("bus_access", 32'(acc(!avm_write_n, avm_address, avm_writedata)), 32'(e));
          end
          if (avm_write_n) rd_cnt = RD_LAT;
          hold_v = 1'b0;
        end else begin
          hold_v = avm_chipselect;
          hold_k = {avm_chipselect, avm_write_n, avm_address, avm_writedata};
        end
        if (tick) begin
          if (exp_tick.size() == 0) begin
            checks++; errors++;
            $display("FAIL tick_unexpected: got count %0d expected no tick", tick_count);
          end else check("tick_count", 32'(tick_count), 32'(exp_tick.pop_front()));
        end
        if (snap_valid) begin
          if (exp_snap.size() == 0) begin
            checks++; errors++;
            $display("FAIL snap_unexpected: got 0x%08h expected no snapshot", snapshot);
          end else check("snapshot", snapshot, exp_snap.pop_front());
        end
      end
    end
  end

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic settle();
    int n;
    wait_idle(n);
    repeat (3) @(negedge clk);
    wait_idle(n);
  endtask

  task automatic check_state();
    check("running", 32'(running), 32'(m_running));
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  // variant: 0 plain, 1 stop while programming, 2 second start while busy
  task automatic op_start(input logic [31:0] per, input bit cont, input int variant, input int exp_n);
    int n;
    exp_acc.push_back(acc(1, 3'd2, per[15:0]));
    exp_acc.push_back(acc(1, 3'd3, per[31:16]));
    exp_acc.push_back(acc(1, 3'd1, cont ? 16'h0007 : 16'h0005));
    m_running = 1'b1;
    if (variant == 1) begin
      exp_acc.push_back(acc(1, 3'd1, 16'h0008));
      m_running = 1'b0;
    end
    @(negedge clk);
    cmd_start = 1'b1; cmd_period = per; cmd_continuous = cont;
    @(negedge clk);
    cmd_start = 1'b0; cmd_period = $urandom; cmd_continuous = 1'($urandom_range(1));
    if (variant == 0) begin
      wait_idle(n);
      if (exp_n > 0) check("start_cycles", 32'(n), 32'(exp_n));
    end else begin
      if (variant == 1) cmd_stop = 1'b1;
      else cmd_start = 1'b1;
      @(negedge clk);
      cmd_stop = 1'b0; cmd_start = 1'b0;
      settle();
    end
    check_state();
  endtask

  task automatic op_irq(input bit run, input bit with_stop);
    int n;
    sts_val = {14'd0, run, 1'($urandom_range(1))};
    exp_acc.push_back(acc(1, 3'd0, 16'h0000));
    exp_acc.push_back(acc(0, 3'd0, 16'h0000));
    m_ticks = m_ticks + 1;
    exp_tick.push_back(m_ticks);
    if (!run) m_running = 1'b0;
    if (with_stop) begin
      exp_acc.push_back(acc(1, 3'd1, 16'h0008));
      m_running = 1'b0;
    end
    @(negedge clk);
    irq_in = 1'b1; cmd_stop = with_stop;
    @(negedge clk);
    irq_in = 1'b0; cmd_stop = 1'b0;
    if (with_stop) settle();
    else begin
      wait_idle(n);
      if (stall_pct == 0) check("irq_cycles", 32'(n), 32'(2 + RD_LAT));
    end
    check_state();
  endtask

  task automatic op_stop();
    int n;
    exp_acc.push_back(acc(1, 3'd1, 16'h0008));
    m_running = 1'b0;
    @(negedge clk);
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
    wait_idle(n);
    if (stall_pct == 0) check("stop_cycles", 32'(n), 32'd1);
    check_state();
  endtask

  task automatic op_snap(input logic [15:0] lo, input logic [15:0] hi);
    int n;
    snap_lo = lo; snap_hi = hi;
`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
    exp_acc.push_back(acc(1, 3'd4, 16'h0000));
    exp_acc.push_back(acc(0, 3'd4, 16'h0000));
    exp_acc.push_back(acc(0, 3'd5, 16'h0000));
    exp_snap.push_back({hi, lo});
`endif
    @(negedge clk);
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    wait_idle(n);
`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
    if (stall_pct == 0) check("snap_cycles", 32'(n), 32'(3 + 2 * RD_LAT));
`else
    check("snap_absent", snapshot, 32'd0);
`endif
    check_state();
  endtask

  initial begin
    reset = 1'b1;
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_period = 32'd0; cmd_continuous = 1'b0;
    snap_req = 1'b0; irq_in = 1'b0;
    sts_val = 16'h0; snap_lo = 16'h0; snap_hi = 16'h0;
    stall_pct = 0; stall_ph = 0; force_wait = 1'b0;
    m_running = 1'b0; m_ticks = '0;
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(avm_chipselect), 32'd0);
    check("rst_write_n", 32'(avm_write_n), 32'd1);
    check("rst_addr", 32'(avm_address), 32'd0);
    check("rst_wdata", 32'(avm_writedata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_tick_count", 32'(tick_count), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_snapshot", snapshot, 32'd0);
    check("rst_snap_valid", 32'(snap_valid), 32'd0);
    reset = 1'b0;

    op_start(32'h0001_86A0, 1'b1, 0, 3);
    op_irq(1'b1, 1'b0);
    op_stop();
    op_start(32'h0000_1000, 1'b0, 0, 3);
    op_irq(1'b0, 1'b0);
    stall_ph = 3;
    op_start(32'hCAFE_0042, 1'b1, 0, 6);
    op_stop();
    op_start(32'h1234_5678, 1'b1, 1, 0);
    op_start(32'h0BAD_F00D, 1'b1, 2, 0);
    op_irq(1'b1, 1'b1);
    op_start(32'h0000_0010, 1'b1, 0, 3);
    op_snap(16'h1234, 16'h0005);
    op_stop();

    stall_pct = 35;
    for (int it = 0; it < 70; it++) begin
      int sel;
      sel = int'($urandom_range(9));
      if (!m_running)
        op_start($urandom, 1'($urandom_range(1)), (sel < 2) ? 1 : (sel < 4) ? 2 : 0, 0);
      else if (sel < 4) op_irq(1'($urandom_range(1)), 1'b0);
      else if (sel < 6) op_irq(1'b1, 1'b1);
      else if (sel < 8) op_snap(16'($urandom), 16'($urandom));
      else op_stop();
    end
    stall_pct = 0;
    if (m_running) op_stop();
    repeat (10) @(negedge clk);
    check("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
    check("tick_queue_empty", 32'(exp_tick.size()), 32'd0);
    check("snap_queue_empty", 32'(exp_snap.size()), 32'd0);
    check("final_tick_count", 32'(tick_count), 32'(m_ticks));

    // Reset while an access is stalled on the bus.
    force_wait = 1'b1;
    @(negedge clk);
    cmd_start = 1'b1; cmd_period = 32'h5555_AAAA;
    @(negedge clk);
    cmd_start = 1'b0;
    @(negedge clk);
    check("stalled_cs", 32'(avm_chipselect), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_drops_cs", 32'(avm_chipselect), 32'd0);
    reset = 1'b0;
    force_wait = 1'b0;
    m_running = 1'b0; m_ticks = '0;
    repeat (5) @(negedge clk);
    check("post_reset_cs", 32'(avm_chipselect), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_running", 32'(running), 32'(m_running));
    check("post_reset_ticks", 32'(tick_count), 32'(m_ticks));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
